rtc_reg_reader: RTL

- Bus-side reader for the RTC's multiplexed address/data interface (ad, cs, wr, rd, shared 8-bit AD bus).
- Counterpart to the existing register writer: it runs an address-latch write cycle, then a read strobe, and returns the register contents.
- Used to fetch time, date and status registers for the display and formatting logic.
- One read per request; fixed 32-tick transaction driven by a tick prescaler.

---
 rtl/rtc_reg_reader.sv | 111 +++++++++++
 1 files changed

// File: rtl/rtc_reg_reader.sv
// Bus-side reader for the RTC multiplexed address/data interface: address-latch
// write cycle, then a read strobe, returning one register per request.
module rtc_reg_reader #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] ADin,
   output logic [7:0] ADout,
   output logic       ad_oe,
   output logic       ad,
   output logic       cs,
   output logic       wr,
   output logic       rd,
   output logic       busy,
   output logic       rvalid,
   output logic [7:0] rdata
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0] PRE_MAX = 8'(CLK_DIV - 1);

   state_t     state;
   logic [4:0] t;
   logic [7:0] pre;
   logic [7:0] addr_q;
   logic [7:0] cap;
   logic [4:0] t_nx;

   assign t_nx = t + 5'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         t      <= '0;
         pre    <= '0;
         addr_q <= '0;
         cap    <= '0;
         ADout  <= '1;
         ad_oe  <= 1'b0;
         ad     <= 1'b1;
         cs     <= 1'b1;
         wr     <= 1'b1;
         rd     <= 1'b1;
         busy   <= 1'b0;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q <= addr;
                  busy   <= 1'b1;
                  state  <= RUN;
                  t      <= '0;
                  pre    <= '0;
                  ad     <= 1'b1;
                  cs     <= 1'b1;
                  wr     <= 1'b1;
                  rd     <= 1'b1;
                  ad_oe  <= 1'b1;
                  ADout  <= '1;
               end
            end
            RUN: begin
               if (pre != PRE_MAX) begin
                  pre <= pre + 8'd1;
               end else begin
                  pre <= '0;
                  if (t == 5'd31) begin
                     state  <= IDLE;
                     t      <= '0;
                     busy   <= 1'b0;
                     rvalid <= 1'b1;
                     rdata  <= cap;
                  end else begin
                     t <= t_nx;
                     // sample on the edge that leaves tick 27, while rd is still low
                     if (t == 5'd27)
                        cap <= ADin;
                     case (t_nx)
                        5'd1:  ad <= 1'b0;
                        5'd2:  cs <= 1'b0;
                        5'd3:  wr <= 1'b0;
                        5'd4:  ADout <= addr_q;
                        5'd9:  wr <= 1'b1;
                        5'd10: cs <= 1'b1;
                        5'd11: ad <= 1'b1;
                        5'd13: begin
                           ADout <= '1;
                           ad_oe <= 1'b0;
                        end
                        5'd21: cs <= 1'b0;
                        5'd22: rd <= 1'b0;
                        5'd28: rd <= 1'b1;
                        5'd29: cs <= 1'b1;
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
